// File: rtl/synth_pkg.sv
// Shared definitions for the synth register-port slice.
package synth_pkg;

    localparam int REGISTER_NUMBER_WIDTH = 8;
    localparam int REGISTER_VALUE_WIDTH  = 24;
    localparam int SPI_FRAME_BITS        = 32;

    // Six bits is enough to count a full frame plus the one-past saturation point.
    localparam int SPI_BIT_COUNT_WIDTH   = 6;

    typedef enum logic [1:0] {
        WAIT_RELEASE = 2'd0,
        IDLE         = 2'd1,
        SHIFT        = 2'd2
    } SpiPortState_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-stage flip-flop synchronizer for a single asynchronous input bit.
module bit_synchronizer #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Sync
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input in at the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_Async};
    end

    // Chain registers; reset loads the input's idle level.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync_q <= {STAGES{RESET_VALUE}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_Sync = sync_q[STAGES-1];

endmodule

// File: rtl/spi_register_port.sv
// SPI mode-0 slave that turns 32-bit write frames into register write strobes
// and echoes the previously accepted frame back on MISO.
//
// Strobe semantics: o_RegisterWriteEnable is a valid-only strobe with no ready
// (no backpressure). o_RegisterNumber/o_RegisterValue are valid in the cycle the
// strobe is high and hold until the next accepted frame.
module spi_register_port
    import synth_pkg::*;
#(
    parameter int REGISTER_NUMBER_WIDTH = synth_pkg::REGISTER_NUMBER_WIDTH,
    parameter int REGISTER_VALUE_WIDTH  = synth_pkg::REGISTER_VALUE_WIDTH,
    parameter int SYNC_STAGES           = 2
) (
    input  logic                             i_Clock,
    input  logic                             i_Reset,
    input  logic                             i_SpiClock,
    input  logic                             i_SpiChipSelect_N,
    input  logic                             i_SpiMosi,
    output logic                             o_SpiMiso,
    output logic [REGISTER_NUMBER_WIDTH-1:0] o_RegisterNumber,
    output logic [REGISTER_VALUE_WIDTH-1:0]  o_RegisterValue,
    output logic                             o_RegisterWriteEnable,
    output logic                             o_FrameError,
    output logic                             o_Busy
);

    localparam int FRAME_BITS = REGISTER_NUMBER_WIDTH + REGISTER_VALUE_WIDTH;
    localparam int CW         = SPI_BIT_COUNT_WIDTH;
    localparam int FLUSH_W    = $clog2(SYNC_STAGES + 1);

    localparam logic [CW-1:0]      COUNT_FULL  = CW'(FRAME_BITS);
    localparam logic [CW-1:0]      COUNT_SAT   = CW'(FRAME_BITS + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_DONE  = FLUSH_W'(SYNC_STAGES);

    // Synchronized SPI inputs
    logic sclk_sync;
    logic cs_n_sync;
    logic mosi_sync;

    bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Async (i_SpiClock),
        .o_Sync  (sclk_sync)
    );

    bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs_n (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Async (i_SpiChipSelect_N),
        .o_Sync  (cs_n_sync)
    );

    bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Async (i_SpiMosi),
        .o_Sync  (mosi_sync)
    );

    // Registered state
    SpiPortState_t                    state_q, state_d;
    logic                             sclk_prev_q, sclk_prev_d;
    logic                             cs_n_prev_q, cs_n_prev_d;
    logic [FLUSH_W-1:0]               flush_count_q, flush_count_d;
    logic [CW-1:0]                    bit_count_q, bit_count_d;
    logic [FRAME_BITS-1:0]            rx_q, rx_d;
    logic [FRAME_BITS-1:0]            tx_q, tx_d;
    logic [REGISTER_NUMBER_WIDTH-1:0] reg_num_q, reg_num_d;
    logic [REGISTER_VALUE_WIDTH-1:0]  reg_val_q, reg_val_d;
    logic                             we_q, we_d;
    logic                             err_q, err_d;
    logic                             busy_q, busy_d;

    // Edge detection; a chip-select edge suppresses any SCLK edge in the same cycle.
    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;

    always_comb begin
        cs_fall   = cs_n_prev_q & ~cs_n_sync;
        cs_rise   = ~cs_n_prev_q & cs_n_sync;
        sclk_rise = ~sclk_prev_q & sclk_sync & ~(cs_fall | cs_rise);
        sclk_fall = sclk_prev_q & ~sclk_sync & ~(cs_fall | cs_rise);
    end

    // Next-state and output logic for the frame state machine.
    always_comb begin
        state_d       = state_q;
        sclk_prev_d   = sclk_sync;
        cs_n_prev_d   = cs_n_sync;
        flush_count_d = flush_count_q;
        bit_count_d   = bit_count_q;
        rx_d          = rx_q;
        tx_d          = tx_q;
        reg_num_d     = reg_num_q;
        reg_val_d     = reg_val_q;
        we_d          = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            WAIT_RELEASE: begin
                tx_d = '0;
                // The synchronizer resets to CS_N high, so only trust its output
                // once the chain has been refilled from the real pin.
                if (flush_count_q != FLUSH_DONE) begin
                    flush_count_d = flush_count_q + 1'b1;
                end else if (cs_n_sync) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                tx_d = '0;
                if (cs_fall) begin
                    state_d     = SHIFT;
                    bit_count_d = '0;
                    tx_d        = {reg_num_q, reg_val_q};
                end
            end

            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    tx_d    = '0;
                    if (bit_count_q == COUNT_FULL) begin
                        reg_num_d = rx_q[FRAME_BITS-1 -: REGISTER_NUMBER_WIDTH];
                        reg_val_d = rx_q[REGISTER_VALUE_WIDTH-1:0];
                        we_d      = 1'b1;
                    end else if (bit_count_q != '0) begin
                        err_d = 1'b1;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_d = {rx_q[FRAME_BITS-2:0], mosi_sync};
                        if (bit_count_q != COUNT_SAT) begin
                            bit_count_d = bit_count_q + 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end

            default: begin
                state_d = WAIT_RELEASE;
                tx_d    = '0;
            end
        endcase

        busy_d = (state_d == SHIFT);
    end

    // State machine and registered outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q       <= WAIT_RELEASE;
            sclk_prev_q   <= 1'b0;
            cs_n_prev_q   <= 1'b1;
            flush_count_q <= '0;
            bit_count_q   <= '0;
            rx_q          <= '0;
            tx_q          <= '0;
            reg_num_q     <= '0;
            reg_val_q     <= '0;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_prev_q   <= sclk_prev_d;
            cs_n_prev_q   <= cs_n_prev_d;
            flush_count_q <= flush_count_d;
            bit_count_q   <= bit_count_d;
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            reg_num_q     <= reg_num_d;
            reg_val_q     <= reg_val_d;
            we_q          <= we_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
        end
    end

    assign o_SpiMiso             = tx_q[FRAME_BITS-1];
    assign o_RegisterNumber      = reg_num_q;
    assign o_RegisterValue       = reg_val_q;
    assign o_RegisterWriteEnable = we_q;
    assign o_FrameError          = err_q;
    assign o_Busy                = busy_q;

endmodule

// File: tb/tb_spi_register_port.sv
// Bench for spi_register_port: directed and random SPI frames checked against
// a frame-level model of the register port.
module tb_spi_register_port;

    // Clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [7:0]  reg_num;
    logic [23:0] reg_val;
    logic        we;
    logic        err;
    logic        busy;

    always #5 clk = ~clk;

    spi_register_port dut (
        .i_Clock               (clk),
        .i_Reset               (rst),
        .i_SpiClock            (sclk),
        .i_SpiChipSelect_N     (cs_n),
        .i_SpiMosi             (mosi),
        .o_SpiMiso             (miso),
        .o_RegisterNumber      (reg_num),
        .o_RegisterValue       (reg_val),
        .o_RegisterWriteEnable (we),
        .o_FrameError          (err),
        .o_Busy                (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Event counters sampled away from the active edge
    int we_total   = 0;
    int err_total  = 0;
    int busy_total = 0;

    always @(negedge clk) begin
        if (we === 1'b1)   we_total++;
        if (err === 1'b1)  err_total++;
        if (busy === 1'b1) busy_total++;
    end

    // Reference model: the last accepted frame is both the output value and the echo
    logic [31:0] model_frame = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Driver: clock nbits of data MSB first, capturing MISO just before each rising SCLK
    task automatic spi_bits(input logic [63:0] data, input int nbits, output logic [63:0] miso_word);
        miso_word = '0;
        for (int b = nbits - 1; b >= 0; b--) begin
            mosi = data[b];
            repeat (5) @(negedge clk);
            miso_word = {miso_word[62:0], miso};
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // Full transaction with frame-level expectations
    task automatic send_frame(input logic [63:0] data, input int nbits, input string tag);
        logic [63:0] miso_word;
        logic [63:0] exp_miso;
        int we0, err0, busy0, first_evt, exp_evt;
        int exp_we, exp_err;
        logic [31:0] next_frame;

        we0 = we_total; err0 = err_total; busy0 = busy_total;
        next_frame = model_frame;
        exp_we = 0; exp_err = 0;
        if (nbits == 32) begin
            exp_we = 1;
            next_frame = data[31:0];
        end else if (nbits != 0) begin
            exp_err = 1;
        end
        if (nbits == 0)       exp_miso = 64'h0;
        else if (nbits <= 32) exp_miso = {32'h0, model_frame} >> (32 - nbits);
        else                  exp_miso = {32'h0, model_frame} << (nbits - 32);
        exp_evt = (exp_we + exp_err > 0) ? 3 : 0;

        cs_n = 1'b0;
        repeat (5) @(negedge clk);
        spi_bits(data, nbits, miso_word);
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
        first_evt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if ((we === 1'b1 || err === 1'b1) && first_evt == 0) first_evt = i;
        end
        model_frame = next_frame;

        check($sformatf("%s_we_count", tag), 64'(we_total - we0), 64'(exp_we));
        check($sformatf("%s_err_count", tag), 64'(err_total - err0), 64'(exp_err));
        check($sformatf("%s_strobe_cycle", tag), 64'(first_evt), 64'(exp_evt));
        check($sformatf("%s_reg_num", tag), 64'(reg_num), 64'(model_frame[31:24]));
        check($sformatf("%s_reg_val", tag), 64'(reg_val), 64'(model_frame[23:0]));
        check($sformatf("%s_miso", tag), miso_word, exp_miso);
        check($sformatf("%s_busy_seen", tag), 64'(busy_total != busy0), 64'd1);
        check($sformatf("%s_busy_idle", tag), 64'(busy), 64'd0);
        check($sformatf("%s_miso_idle", tag), 64'(miso), 64'd0);
    endtask

    initial begin
        logic [63:0] junk;
        int we0, err0;
        int nbits;
        logic [63:0] data;

        // Reset values
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_reg_num", 64'(reg_num), 64'h0);
        check("rst_reg_val", 64'(reg_val), 64'h0);
        check("rst_we", 64'(we), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_miso", 64'(miso), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Directed frames
        send_frame(64'h02123456, 32, "first");
        send_frame(64'h15000001, 32, "second");
        send_frame(64'h000ABCDE, 20, "short20");
        send_frame(64'h1_2345_6789, 33, "long33");

        // Reset in the middle of a frame, remaining bits must be ignored
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
        spi_bits(64'hA5, 10, junk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_frame = 32'h0;
        @(negedge clk);
        check("midrst_reg_num", 64'(reg_num), 64'h0);
        check("midrst_reg_val", 64'(reg_val), 64'h0);
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_miso", 64'(miso), 64'h0);
        we0 = we_total; err0 = err_total;
        spi_bits(64'h3FFFFF, 22, junk);
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_we_count", 64'(we_total - we0), 64'h0);
        check("midrst_err_count", 64'(err_total - err0), 64'h0);
        check("midrst_busy_after", 64'(busy), 64'h0);
        send_frame(64'h05ABCDEF, 32, "after_rst");

        // Chip-select pulse with no SCLK activity
        send_frame(64'h0, 0, "cs_pulse");

        // Random frames, mostly well-formed
        for (int i = 0; i < 8; i++) begin
            data = {$urandom, $urandom};
            nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 33) : 32;
            send_frame(data, nbits, $sformatf("rand%0d_n%0d", i, nbits));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_register_port.md
Name: spi_register_port

Overview:
- SPI slave that replaces the parallel register-write bus feeding the synth top level.
- Receives 32-bit write frames from an external controller. Each frame carries an 8-bit register number and a 24-bit register value.
- Emits a single-cycle write strobe in the i_Clock domain.
- Shifts the previously accepted frame back out on MISO so the controller can confirm what was written.

Parameters:
- REGISTER_NUMBER_WIDTH, 8, width of o_RegisterNumber.
- REGISTER_VALUE_WIDTH, 24, width of o_RegisterValue.
- SYNC_STAGES, 2, flip-flop stages on each SPI input. Minimum 2.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  reset: synchronous, active-high.
- i_SpiClock  in  1  SCLK, asynchronous to i_Clock. Idle low.
- i_SpiChipSelect_N  in  1  chip select, active low, asynchronous.
- i_SpiMosi  in  1  serial data in, MSB first.
- o_SpiMiso  out  1  serial data out, MSB first.
- o_RegisterNumber  out  8  register number of the last accepted frame.
- o_RegisterValue  out  24  register value of the last accepted frame.
- o_RegisterWriteEnable  out  1  one-cycle strobe when a frame is accepted.
- o_FrameError  out  1  one-cycle strobe when a malformed frame is discarded.
- o_Busy  out  1  high while in SHIFT.

Behaviour:
- SPI mode 0 (CPOL=0, CPHA=0).
  - MOSI is sampled on SCLK rising.
  - MISO changes on SCLK falling.
- Frame format: 32 bits, MSB first. Bits [31:24] are the register number; bits [23:0] are the register value.
- Input conditioning:
  - Each SPI input passes through SYNC_STAGES flip-flops.
  - SCLK and CS edges are detected by comparing the last sync stage with one further delay register.
  - Requirement on the master: SCLK high and low times ≥ 4 i_Clock periods.
  - Requirement on the master: CS_N setup to the first SCLK rising edge ≥ 4 i_Clock periods.
  - Requirement on the master: CS_N hold after the last SCLK falling edge ≥ 4 i_Clock periods.
- State machine:
  - WAIT_RELEASE (reset state): go to IDLE when synced CS_N is high.
  - IDLE: on a synced CS_N falling edge, go to SHIFT. Clear the 6-bit bit counter. Load the tx shift register with the last accepted frame.
  - SHIFT, on an SCLK rising edge: shift MOSI into the rx shift register LSB. Increment the bit counter, saturating at 33.
  - SHIFT, on an SCLK falling edge: shift the tx register left, filling with 0.
  - SHIFT, on a CS_N rising edge: go to IDLE.
    - Counter == 32: latch rx[31:24] into o_RegisterNumber and rx[23:0] into o_RegisterValue. Assert o_RegisterWriteEnable for exactly 1 cycle. The latched frame becomes the next echo value.
    - Counter in 1..31 or 33: assert o_FrameError for 1 cycle. No write. Outputs hold.
    - Counter == 0: silently ignored.
- Strobe timing:
  - o_RegisterNumber, o_RegisterValue and the strobe are registered and update in the same cycle.
  - The strobe is high during the cycle following the (SYNC_STAGES+1)th i_Clock rising edge, counting the edge that first samples raw CS_N high.
- MISO:
  - o_SpiMiso = tx[31] at all times.
  - The first bit is valid SYNC_STAGES+1 cycles after raw CS_N falls.
  - MISO is driven 0 in IDLE and WAIT_RELEASE.
- Simultaneous edges: if SCLK and CS_N edges are detected in the same cycle, the CS_N edge wins and the SCLK edge is dropped.
- Reset values:
  - o_RegisterNumber = 0, o_RegisterValue = 0.
  - o_RegisterWriteEnable = 0, o_FrameError = 0.
  - o_SpiMiso = 0, o_Busy = 0.
  - Echo frame = 0. Synchronizers cleared to CS_N = 1 and SCLK = 0.
- Reset mid-frame: the partial frame is discarded with no write and no error. The block enters WAIT_RELEASE and ignores all traffic until CS_N has been seen high.
- Back-to-back frames: CS_N high for ≥ 4 i_Clock cycles between frames. Each frame is handled independently.

Decomposition:
- Package synth_pkg:
  - REGISTER_NUMBER_WIDTH, REGISTER_VALUE_WIDTH.
  - SPI_FRAME_BITS = 32.
  - SpiPortState_t enum {WAIT_RELEASE, IDLE, SHIFT}.
- Sub-module bit_synchronizer (parameter STAGES, RESET_VALUE).
  - Instantiated three times, once per SPI input.
  - Reusable for later asynchronous inputs.

Test Plan:
- Send frame 0x02123456 with SCLK period of 10 clk → one strobe, o_RegisterNumber = 0x02, o_RegisterValue = 0x123456. o_FrameError stays 0.
- Send 0x02123456, then 0x15000001 → second write has number 0x15, value 0x000001. MISO during the second frame reads 0x02123456. MISO during the first frame after reset reads 0x00000000.
- Send a 20-bit frame after a good write → o_FrameError pulses once, no strobe, outputs unchanged.
- Send a 33-bit frame → o_FrameError pulses once, no strobe.
- Assert i_Reset at bit 10 with CS_N held low, then clock the remaining 22 bits → no strobe, no error. The next full frame 0x05ABCDEF is accepted normally.
- Pulse CS_N low then high with no SCLK edges → no strobe, no error, o_Busy pulses.
